// File: rtl/mmu_arbiter_wrr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mmu_arbiter_wrr - N_CH-way RR / weighted-RR / priority DMA request arbiter
// with per-channel outstanding credits and a parallel ordering-record slot.
// Rev 1.0
// ---------------------------------------------------------------------------
module mmu_arbiter_wrr #(
  parameter int N_CH     = 4,
  parameter int REQ_BITS = 96,
  parameter int LEN_BITS = 28,
  parameter int WGT_BITS = 4,
  parameter int N_OUT    = 8,
  parameter int MODE     = 1
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [N_CH-1:0]          s_req_valid,
  output logic [N_CH-1:0]          s_req_ready,
  input  logic [N_CH*REQ_BITS-1:0] s_req_data,
  output logic                     m_req_valid,
  input  logic                     m_req_ready,
  output logic [REQ_BITS-1:0]      m_req_data,
  output logic                     m_mux_valid,
  input  logic                     m_mux_ready,
  output logic [4+LEN_BITS-1:0]    m_mux_data,
  input  logic [N_CH*WGT_BITS-1:0] cnfg_weight,
  input  logic [N_CH-1:0]          done,
  output logic [N_CH-1:0]          credit_err
);
  localparam int CW = $clog2(N_OUT + 1);
  localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CW-1:0] C_N_OUT = CW'(N_OUT);

  logic [CW-1:0]       inflight_q [N_CH];
  logic [CW-1:0]       inflight_d [N_CH];
  logic [N_CH-1:0]     credit_err_q, credit_err_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [WGT_BITS-1:0] burst_q, burst_d;
  logic                m_req_valid_q, m_req_valid_d;
  logic [REQ_BITS-1:0] m_req_data_q, m_req_data_d;
  logic                m_mux_valid_q, m_mux_valid_d;
  logic [4+LEN_BITS-1:0] m_mux_data_q, m_mux_data_d;

  logic [N_CH-1:0]     elig;
  logic                can_load, grant_en;
  logic [PW-1:0]       grant_idx;
  logic                rr_found, nx_found, lo_found;
  logic [PW-1:0]       rr_idx, nx_idx, lo_idx, at_idx, after_idx;
  logic [WGT_BITS-1:0] wgt_ptr;
  logic [REQ_BITS-1:0] grant_word;
  int                  j_at, j_after;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    assign elig[i] = s_req_valid[i] && (inflight_q[i] < C_N_OUT) &&
                     ((MODE == 2) || (cnfg_weight[i*WGT_BITS +: WGT_BITS] != '0));
    assign s_req_ready[i] = grant_en && (int'(grant_idx) == i);
  end

  always_comb begin
    can_load = (!m_req_valid_q || m_req_ready) && (!m_mux_valid_q || m_mux_ready);
    rr_found = 1'b0; rr_idx = '0;
    nx_found = 1'b0; nx_idx = '0;
    lo_found = 1'b0; lo_idx = '0;
    j_at = 0; j_after = 0; at_idx = '0; after_idx = '0;
    // rr: first eligible at/after ptr; nx: first eligible strictly after ptr (ptr itself last)
    for (int k = 0; k < N_CH; k++) begin
      j_at = int'(ptr_q) + k;
      if (j_at >= N_CH) j_at = j_at - N_CH;
      j_after = int'(ptr_q) + k + 1;
      if (j_after >= N_CH) j_after = j_after - N_CH;
      at_idx    = PW'(j_at);
      after_idx = PW'(j_after);
      if (!rr_found && elig[at_idx]) begin rr_found = 1'b1; rr_idx = at_idx; end
      if (!nx_found && elig[after_idx]) begin nx_found = 1'b1; nx_idx = after_idx; end
      if (!lo_found && elig[PW'(k)]) begin lo_found = 1'b1; lo_idx = PW'(k); end
    end

    wgt_ptr   = cnfg_weight[int'(ptr_q)*WGT_BITS +: WGT_BITS];
    grant_en  = 1'b0;
    grant_idx = '0;
    ptr_d     = ptr_q;
    burst_d   = burst_q;
    if (MODE == 0) begin
      if (can_load && rr_found) begin
        grant_en  = 1'b1;
        grant_idx = rr_idx;
        ptr_d     = (int'(rr_idx) == N_CH - 1) ? '0 : rr_idx + 1'b1;
      end
    end else if (MODE == 1) begin
      if (elig[ptr_q]) begin
        if (can_load) begin
          grant_en  = 1'b1;
          grant_idx = ptr_q;
          if (({1'b0, burst_q} + 1'b1) >= {1'b0, wgt_ptr}) begin
            ptr_d   = nx_idx;
            burst_d = '0;
          end else begin
            burst_d = burst_q + 1'b1;
          end
        end
      end else if (nx_found) begin
        ptr_d   = nx_idx;
        burst_d = '0;
      end
    end else begin
      if (can_load && lo_found) begin
        grant_en  = 1'b1;
        grant_idx = lo_idx;
      end
    end

    grant_word    = s_req_data[int'(grant_idx)*REQ_BITS +: REQ_BITS];
    m_req_valid_d = m_req_valid_q && !m_req_ready;
    m_req_data_d  = m_req_data_q;
    m_mux_valid_d = m_mux_valid_q && !m_mux_ready;
    m_mux_data_d  = m_mux_data_q;
    if (grant_en) begin
      m_req_valid_d = 1'b1;
      m_req_data_d  = grant_word;
      m_mux_valid_d = 1'b1;
      m_mux_data_d  = {4'(grant_idx), grant_word[LEN_BITS-1:0]};
    end

    for (int i = 0; i < N_CH; i++) begin
      inflight_d[i]   = inflight_q[i];
      credit_err_d[i] = credit_err_q[i];
      if (done[i] && (inflight_q[i] == '0)) credit_err_d[i] = 1'b1;
      if (grant_en && (int'(grant_idx) == i)) inflight_d[i] = inflight_d[i] + 1'b1;
      if (done[i] && (inflight_q[i] != '0)) inflight_d[i] = inflight_d[i] - 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < N_CH; i++) inflight_q[i] <= '0;
      credit_err_q  <= '0;
      ptr_q         <= '0;
      burst_q       <= '0;
      m_req_valid_q <= 1'b0;
      m_req_data_q  <= '0;
      m_mux_valid_q <= 1'b0;
      m_mux_data_q  <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) inflight_q[i] <= inflight_d[i];
      credit_err_q  <= credit_err_d;
      ptr_q         <= ptr_d;
      burst_q       <= burst_d;
      m_req_valid_q <= m_req_valid_d;
      m_req_data_q  <= m_req_data_d;
      m_mux_valid_q <= m_mux_valid_d;
      m_mux_data_q  <= m_mux_data_d;
    end
  end

  assign m_req_valid = m_req_valid_q;
  assign m_req_data  = m_req_data_q;
  assign m_mux_valid = m_mux_valid_q;
  assign m_mux_data  = m_mux_data_q;
  assign credit_err  = credit_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mmu_arbiter_wrr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mmu_arbiter_wrr - scoreboard bench running one instance per arbitration mode.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mmu_arbiter_wrr;
  localparam int NC = 4;
  localparam int RB = 96;
  localparam int LB = 28;
  localparam int NO = 8;
  localparam int ND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn;
  logic [NC-1:0]     sv;
  logic [NC*RB-1:0]  sd;
  logic              mrr, mmr;
  logic [15:0]       wgt;
  logic [NC-1:0]     dn    [ND];
  logic [NC-1:0]     s_rdy [ND];
  logic              mrv   [ND];
  logic [RB-1:0]     mrd   [ND];
  logic              mmv   [ND];
  logic [4+LB-1:0]   mmd   [ND];
  logic [NC-1:0]     cerr  [ND];

  for (genvar m = 0; m < ND; m++) begin : g_dut
    mmu_arbiter_wrr #(
      .N_CH(NC), .REQ_BITS(RB), .LEN_BITS(LB), .WGT_BITS(4), .N_OUT(NO), .MODE(m)
    ) u_dut (
      .aclk(clk), .aresetn(rstn),
      .s_req_valid(sv), .s_req_ready(s_rdy[m]), .s_req_data(sd),
      .m_req_valid(mrv[m]), .m_req_ready(mrr), .m_req_data(mrd[m]),
      .m_mux_valid(mmv[m]), .m_mux_ready(mmr), .m_mux_data(mmd[m]),
      .cnfg_weight(wgt), .done(dn[m]), .credit_err(cerr[m])
    );
  end

  // Reference model state, one set per mode instance
  int  inf   [ND][NC];
  bit  err   [ND][NC];
  int  ptr   [ND];
  int  burst [ND];
  bit  rf    [ND];
  bit  mf    [ND];
  logic [RB-1:0]   exp_req [ND][$];
  logic [4+LB-1:0] exp_mux [ND][$];

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: actual=%0h required=%0h", nm, got, exp);
    end
  endtask

  function automatic int wt(input int i);
    return int'(wgt[i*4 +: 4]);
  endfunction

  task automatic model_dut(input int m);
    bit el [NC];
    bit can, any;
    int g, np, c;
    logic [NC-1:0] exp_rdy;
    logic [RB-1:0] w;
    if (!rstn) begin
      for (int i = 0; i < NC; i++) begin inf[m][i] = 0; err[m][i] = 0; end
      ptr[m] = 0; burst[m] = 0; rf[m] = 0; mf[m] = 0;
      exp_req[m].delete();
      exp_mux[m].delete();
      return;
    end
    for (int i = 0; i < NC; i++)
      chk($sformatf("credit_err[%0d] mode%0d", i, m), 128'(cerr[m][i]), 128'(err[m][i]));
    any = 0;
    for (int i = 0; i < NC; i++) begin
      el[i] = sv[i] && (inf[m][i] < NO) && ((m == 2) || (wt(i) != 0));
      any = any | el[i];
    end
    can = (!rf[m] || mrr) && (!mf[m] || mmr);
    g = -1;
    np = ptr[m];
    for (int k = 1; k <= NC; k++) begin
      c = (ptr[m] + k) % NC;
      if (el[c] && np == ptr[m] && !(k == NC && !el[ptr[m]])) np = c;
    end
    if (m == 0) begin
      if (can)
        for (int k = 0; k < NC; k++) begin
          c = (ptr[m] + k) % NC;
          if (el[c] && g < 0) g = c;
        end
      if (g >= 0) ptr[m] = (g + 1) % NC;
    end else if (m == 1) begin
      if (el[ptr[m]]) begin
        if (can) begin
          g = ptr[m];
          if (burst[m] + 1 == wt(ptr[m])) begin ptr[m] = np; burst[m] = 0; end
          else burst[m] = burst[m] + 1;
        end
      end else if (any) begin
        ptr[m] = np;
        burst[m] = 0;
      end
    end else begin
      if (can)
        for (int k = 0; k < NC; k++) if (el[k] && g < 0) g = k;
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk($sformatf("s_req_ready mode%0d", m), 128'(s_rdy[m]), 128'(exp_rdy));
    if (g >= 0) begin
      w = sd[g*RB +: RB];
      exp_req[m].push_back(w);
      exp_mux[m].push_back({4'(g), w[LB-1:0]});
    end
    for (int i = 0; i < NC; i++) begin
      if (dn[m][i] && inf[m][i] == 0) err[m][i] = 1;
      if (g == i) inf[m][i]++;
      if (dn[m][i] && inf[m][i] > 0 && !(g == i && inf[m][i] == 1 && err[m][i] && dn[m][i] && 0)) begin
        if (!(g == i) || inf[m][i] > 1 || 1) inf[m][i] = inf[m][i] - ((dn[m][i] && (inf[m][i] - ((g == i) ? 1 : 0)) > 0) ? 1 : 0);
      end
    end
    rf[m] = (g >= 0) || (rf[m] && !mrr);
    mf[m] = (g >= 0) || (mf[m] && !mmr);
  endtask

  // Monitor: pops the scoreboard whenever an output slot handshakes
  initial begin
    forever begin
      @(negedge clk);
      #2;
      for (int m = 0; m < ND; m++) begin
        if (rstn === 1'b1 && mrv[m] === 1'b1 && mrr === 1'b1) begin
          if (exp_req[m].size() == 0) begin
            n_vec++; n_mis++;
            $display("FAIL m_req_unexpected mode%0d: actual=%0h required=none", m, mrd[m]);
          end else chk($sformatf("m_req_data mode%0d", m), 128'(mrd[m]), 128'(exp_req[m].pop_front()));
        end
        if (rstn === 1'b1 && mmv[m] === 1'b1 && mmr === 1'b1) begin
          if (exp_mux[m].size() == 0) begin
            n_vec++; n_mis++;
            $display("FAIL m_mux_unexpected mode%0d: actual=%0h required=none", m, mmd[m]);
          end else chk($sformatf("m_mux_data mode%0d", m), 128'(mmd[m]), 128'(exp_mux[m].pop_front()));
        end
      end
    end
  end

  task automatic clear_done();
    for (int m = 0; m < ND; m++) dn[m] = '0;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NC*RB/32; i++) sd[i*32 +: 32] = $urandom();
  endtask

  task automatic step();
    #1;
    for (int m = 0; m < ND; m++) model_dut(m);
    @(negedge clk);
  endtask

  task automatic drive(input logic [NC-1:0] v, input logic rr, input logic mr, input int dpct);
    sv = v; mrr = rr; mmr = mr;
    rand_data();
    for (int m = 0; m < ND; m++)
      for (int i = 0; i < NC; i++)
        dn[m][i] = (inf[m][i] > 0) && (int'($urandom_range(99)) < dpct);
    step();
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b0; sv = '0; mrr = 1'b0; mmr = 1'b0;
    clear_done();
    repeat (n) step();
    rstn = 1'b1;
  endtask

  task automatic check_reset();
    sv = '0; mrr = 1'b0; mmr = 1'b0;
    clear_done();
    #1;
    for (int m = 0; m < ND; m++) begin
      chk($sformatf("rst m_req_valid mode%0d", m), 128'(mrv[m]), 128'(0));
      chk($sformatf("rst m_mux_valid mode%0d", m), 128'(mmv[m]), 128'(0));
      chk($sformatf("rst m_req_data mode%0d", m), 128'(mrd[m]), 128'(0));
      chk($sformatf("rst m_mux_data mode%0d", m), 128'(mmd[m]), 128'(0));
      chk($sformatf("rst credit_err mode%0d", m), 128'(cerr[m]), 128'(0));
      model_dut(m);
    end
    @(negedge clk);
  endtask

  task automatic drain_credits();
    sv = '0; mrr = 1'b1; mmr = 1'b1;
    repeat (NO + 1) begin
      for (int m = 0; m < ND; m++)
        for (int i = 0; i < NC; i++) dn[m][i] = (inf[m][i] > 0);
      step();
    end
    clear_done();
  endtask

  initial begin
    rstn = 1'b0; sv = '0; sd = '0; mrr = 1'b0; mmr = 1'b0;
    wgt = 16'h0213;  // ch0=3, ch1=1, ch2=2, ch3=0
    clear_done();
    do_reset(3);
    check_reset();

    // Full throughput, all channels requesting
    repeat (12) drive(4'hF, 1'b1, 1'b1, 0);

    // Credit limit on channel 0, then one credit returned
    drain_credits();
    repeat (12) drive(4'h1, 1'b1, 1'b1, 0);
    sv = 4'h1; mrr = 1'b1; mmr = 1'b1; rand_data();
    for (int m = 0; m < ND; m++) dn[m] = (inf[m][0] > 0) ? 4'h1 : 4'h0;
    step();
    clear_done();
    repeat (4) drive(4'h1, 1'b1, 1'b1, 0);

    // Ordering-record backpressure, then release
    drain_credits();
    repeat (6) drive(4'hF, 1'b1, 1'b0, 0);
    repeat (6) drive(4'hF, 1'b1, 1'b1, 0);

    // Channels 1 and 3 only, then channel 3 alone
    drain_credits();
    repeat (5) drive(4'b1010, 1'b1, 1'b1, 0);
    repeat (3) drive(4'b1000, 1'b1, 1'b1, 0);

    // Completion with nothing in flight
    drain_credits();
    sv = '0;
    for (int m = 0; m < ND; m++) dn[m] = 4'b0100;
    step();
    clear_done();
    repeat (3) drive('0, 1'b1, 1'b1, 0);

    // Reset while the output slots hold a request
    drive(4'hF, 1'b1, 1'b1, 0);
    drive(4'hF, 1'b0, 1'b0, 0);
    for (int m = 0; m < ND; m++)
      chk($sformatf("pre-reset m_req_valid mode%0d", m), 128'(mrv[m]), 128'(1));
    do_reset(1);
    check_reset();

    // Randomized traffic with random weights
    repeat (2) begin
      for (int i = 0; i < NC; i++) wgt[i*4 +: 4] = 4'($urandom_range(4));
      do_reset(2);
      repeat (1500)
        drive(NC'($urandom()), int'($urandom_range(99)) < 75, int'($urandom_range(99)) < 75, 25);
    end

    repeat (4) drive('0, 1'b1, 1'b1, 0);
    for (int m = 0; m < ND; m++) begin
      chk($sformatf("req leftovers mode%0d", m), 128'(exp_req[m].size()), 128'(0));
      chk($sformatf("mux leftovers mode%0d", m), 128'(exp_mux[m].size()), 128'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mmu_arbiter_wrr.md
# mmu_arbiter_wrr

Parametrised successor to the per-region DMA request arbiter in the MMU. It merges `N_CH` per-region request streams into one DMA request stream and emits, for every grant, an ordering record (channel id + length) for the downstream data mux. Three arbitration modes are supported: round-robin, weighted round-robin and strict priority. A per-channel outstanding-request credit limit is enforced, with credits returned by completion pulses. It sits between the region MMUs and the host/card DMA engines.

## Interface
Parameters:
- `N_CH`, 4: number of request channels (1..16).
- `REQ_BITS`, 96: width of one request word; bits `[LEN_BITS-1:0]` of each request carry the transfer length.
- `LEN_BITS`, 28: length field width.
- `WGT_BITS`, 4: per-channel weight width.
- `N_OUT`, 8: maximum outstanding (granted, not completed) requests per channel.
- `MODE`, 1: 0 = round-robin, 1 = weighted round-robin, 2 = strict priority (lowest index wins).

Ports:
- `aclk`, in, 1: clock.
- `aresetn`, in, 1: synchronous reset, active-low.
- `s_req_valid`, in, N_CH: per-channel request valid.
- `s_req_ready`, out, N_CH: per-channel request accept; at most one bit high per cycle.
- `s_req_data`, in, N_CH×REQ_BITS: per-channel request word.
- `m_req_valid`, out, 1: merged request valid.
- `m_req_ready`, in, 1: merged request accept.
- `m_req_data`, out, REQ_BITS: merged request word.
- `m_mux_valid`, out, 1: ordering record valid.
- `m_mux_ready`, in, 1: ordering record accept.
- `m_mux_data`, out, 4+LEN_BITS: `{ch_id[3:0], len}`.
- `cnfg_weight`, in, N_CH×WGT_BITS: per-channel weight. Weight 0 disables the channel in modes 0 and 1.
- `done`, in, N_CH: completion pulse; returns one credit.
- `credit_err`, out, N_CH: sticky flag, set by a `done` pulse while the channel's in-flight count is 0.

## Operation
- Channel eligibility: `s_req_valid[i]` is high, `inflight[i] < N_OUT`, and (`MODE`=2 or `cnfg_weight[i]` is non-zero).
- Output stage: one register slot for `m_req` and one for `m_mux`. Both are loaded in the same cycle.
- Grant condition: the `m_req` slot is empty or firing this cycle, the `m_mux` slot is empty or firing this cycle, and at least one channel is eligible.
- On grant to channel g:
  - `s_req_ready[g]` is high for that cycle.
  - Both slots load next edge.
  - `inflight[g]` increments.
- Arbitration state: pointer `ptr` (reset 0) and burst counter `burst` (reset 0).
- MODE 0:
  - Grant goes to the first eligible channel at or after `ptr`, wrapping modulo N_CH.
  - After the grant, `ptr` = g+1 mod N_CH.
- MODE 1:
  - If `ptr` is eligible, it is granted and `burst` increments.
  - When `burst`+1 = `cnfg_weight[ptr]`, or `ptr` is not eligible: `ptr` moves to the next eligible channel after it (wrapping) and `burst` is cleared.
  - A channel therefore receives up to `weight` consecutive grants while it stays eligible.
  - `cnfg_weight` is sampled at each grant.
- MODE 2: the lowest-index eligible channel is granted. `ptr` and `burst` are unused.
- Credits:
  - `inflight[i]` is `$clog2(N_OUT+1)` bits wide.
  - Grant and `done` in the same cycle on the same channel: count unchanged.
  - `done` while the count is 0: count stays 0 and `credit_err[i]` is set. It is cleared only by reset.
- The `m_req` and `m_mux` slots drain independently. No new grant is made until both slots can accept.

## Timing
- Reset values: `m_req_valid`=0, `m_mux_valid`=0, `m_req_data`=0, `m_mux_data`=0, `s_req_ready`=0, `credit_err`=0, all `inflight`=0, `ptr`=0, `burst`=0.
- `s_req_ready` is combinational from `s_req_valid`, the credit counts, the weights and the slot state. It never depends on `s_req_ready` itself.
- Latency: a request accepted in cycle t appears as `m_req_valid`/`m_mux_valid` at t+1.
- Throughput: one grant per cycle while `m_req_ready`=`m_mux_ready`=1.
- Valid/ready rules:
  - Once `m_*_valid` is asserted, it and its data hold until the matching ready is seen.
  - A slot's valid deasserts the cycle after its handshake unless the slot is reloaded.
- A credit returned by `done` at cycle t makes the channel eligible in cycle t+1, not in cycle t.
- Reset asserted mid-transfer: both slots are dropped, all counts are cleared, and nothing is emitted after the reset edge.

## Test plan
- MODE 0, N_CH=4, all channels valid continuously, both readies high → grants in order 0,1,2,3,0,1…; `m_mux_data` ch_id follows the same order; one grant per cycle.
- MODE 1, weights {3,1,2,0}, all valid → repeating grant pattern 0,0,0,1,2,2; channel 3 is never granted.
- Credit limit, N_OUT=8: channel 0 alone valid with no `done` → exactly 8 grants, then `s_req_ready[0]`=0. A single `done[0]` pulse at cycle t → exactly one more grant at t+1.
- Backpressure: hold `m_mux_ready`=0 with `m_req_ready`=1 → exactly one request issued, data held stable, no further `s_req_ready`. Releasing `m_mux_ready` resumes grants.
- MODE 2, channels 1 and 3 valid → only channel 1 is granted until it deasserts, then channel 3.
- `done[2]` with `inflight[2]`=0 → `credit_err[2]`=1, count stays 0. Assert `aresetn`=0 for one cycle while `m_req_valid`=1 → all outputs return to their reset values on the next edge.
